// File: rtl/pingpong_pkg.sv
// Shared types and constants for the ping-pong bank drainer.
// PINGPONG_DRAIN_CSUM_EN adds the CSUM state (trailing checksum byte).
package pingpong_pkg;

    localparam int BANK_ADDR_W = 8;
    localparam int BANK_BYTES  = 256;

`ifdef PINGPONG_DRAIN_CSUM_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RADDR = 3'd1,
        RDATA = 3'd2,
        SEND  = 3'd3,
        CSUM  = 3'd4
    } drain_state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RADDR = 3'd1,
        RDATA = 3'd2,
        SEND  = 3'd3
    } drain_state_t;
`endif

endpackage

// File: rtl/pingpong_drain_bank_flip_det.sv
// Bank flip detector: tracks the writer's bank bit and records
// flips that land during a drain as pending work plus a sticky overrun.
module bank_flip_det (
    input  logic clk,
    input  logic rst,
    input  logic bank_sel,
    input  logic busy,
    input  logic start,
    output logic start_req,
    output logic overrun
);

    logic bank_q;
    logic pending;
    logic flip;

    assign flip      = bank_sel ^ bank_q;
    assign start_req = flip | pending;

    // Reset loads bank_q from bank_sel so no flip is seen on exit.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q  <= bank_sel;
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            bank_q <= bank_sel;
            if (flip && busy) begin
                pending <= 1'b1;
                overrun <= 1'b1;
            end else if (start) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pingpong_drain.sv
// Drains the read bank of a ping-pong RAM byte by byte over valid/ready.
// PINGPONG_DRAIN_CSUM_EN appends a mod-256 checksum byte to each drain.
module pingpong_drain
    import pingpong_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   bank_sel,
    output logic [BANK_ADDR_W-1:0] read_addr,
    input  logic [7:0]             ram_dout,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   busy,
    output logic                   overrun
);

    if (DEPTH < 1 || DEPTH > BANK_BYTES) begin : g_depth_chk
        $error("DEPTH out of range");
    end

    localparam logic [BANK_ADDR_W-1:0] LAST = BANK_ADDR_W'(DEPTH - 1);

    drain_state_t           state;
    drain_state_t           state_d;
    logic [BANK_ADDR_W-1:0] addr_d;
    logic [7:0]             data_d;
    logic                   valid_d;
    logic                   start_req;
    logic                   start;
    logic                   xfer;

`ifdef PINGPONG_DRAIN_CSUM_EN
    logic [7:0] csum;
    logic [7:0] csum_d;
`endif

    assign busy  = (state != IDLE);
    assign start = (state == IDLE) && start_req;
    assign xfer  = tx_valid && tx_ready;

    bank_flip_det u_flip (
        .clk       (clk),
        .rst       (rst),
        .bank_sel  (bank_sel),
        .busy      (busy),
        .start     (start),
        .start_req (start_req),
        .overrun   (overrun)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            read_addr <= '0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
`ifdef PINGPONG_DRAIN_CSUM_EN
            csum      <= '0;
`endif
        end else begin
            state     <= state_d;
            read_addr <= addr_d;
            tx_data   <= data_d;
            tx_valid  <= valid_d;
`ifdef PINGPONG_DRAIN_CSUM_EN
            csum      <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d = state;
        addr_d  = read_addr;
        data_d  = tx_data;
        valid_d = tx_valid;
`ifdef PINGPONG_DRAIN_CSUM_EN
        csum_d  = csum;
`endif
        unique case (state)
            IDLE: begin
                if (start_req) begin
                    state_d = RADDR;
                    addr_d  = '0;
`ifdef PINGPONG_DRAIN_CSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            RADDR: begin
                state_d = RDATA;
            end
            RDATA: begin
                data_d  = ram_dout;
                valid_d = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                if (xfer) begin
`ifdef PINGPONG_DRAIN_CSUM_EN
                    csum_d = csum + tx_data;
`endif
                    if (read_addr == LAST) begin
`ifdef PINGPONG_DRAIN_CSUM_EN
                        // Checksum goes out next with valid still high.
                        state_d = CSUM;
                        data_d  = csum + tx_data;
`else
                        state_d = IDLE;
                        valid_d = 1'b0;
`endif
                    end else begin
                        addr_d  = read_addr + 1'b1;
                        valid_d = 1'b0;
                        state_d = RADDR;
                    end
                end
            end
`ifdef PINGPONG_DRAIN_CSUM_EN
            CSUM: begin
                if (xfer) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_pingpong_drain.sv
// Directed bench for pingpong_drain (DEPTH=256 and DEPTH=4 instances).
// Defining PINGPONG_DRAIN_CSUM_EN also checks the trailing checksum byte.
module tb_pingpong_drain;

`ifdef PINGPONG_DRAIN_CSUM_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int DLEN  = 256 + EXTRA;
    localparam int DLEN4 = 4 + EXTRA;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bank_sel = 1'b0;
    logic [7:0] read_addr;
    logic [7:0] ram_dout = 8'h00;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic       busy;
    logic       overrun;

    logic       bank_sel4 = 1'b0;
    logic [7:0] read_addr4;
    logic [7:0] ram_dout4 = 8'h00;
    logic [7:0] tx_data4;
    logic       tx_valid4;
    logic       tx_ready4 = 1'b1;
    logic       busy4;
    logic       overrun4;

    logic [7:0] mem  [256];
    logic [7:0] mem4 [256];
    logic [7:0] rx   [$];
    logic [7:0] rx4  [$];
    logic [7:0] exp  [$];
    int         max4 = 0;

    int checks = 0;
    int errors = 0;

    pingpong_drain dut (
        .clk       (clk),
        .rst       (rst),
        .bank_sel  (bank_sel),
        .read_addr (read_addr),
        .ram_dout  (ram_dout),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .overrun   (overrun)
    );

    pingpong_drain #(.DEPTH(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .bank_sel  (bank_sel4),
        .read_addr (read_addr4),
        .ram_dout  (ram_dout4),
        .tx_data   (tx_data4),
        .tx_valid  (tx_valid4),
        .tx_ready  (tx_ready4),
        .busy      (busy4),
        .overrun   (overrun4)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM models: data one clock after the address.
    always @(posedge clk) begin
        ram_dout  <= mem[read_addr];
        ram_dout4 <= mem4[read_addr4];
    end

    always @(negedge clk) begin
        if (tx_valid && tx_ready)
            rx.push_back(tx_data);
        if (tx_valid4 && tx_ready4)
            rx4.push_back(tx_data4);
        if (int'(read_addr4) > max4)
            max4 = int'(read_addr4);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic build_exp(input int drains);
        logic [7:0] s;
        exp.delete();
        for (int d = 0; d < drains; d++) begin
            s = 8'h00;
            for (int i = 0; i < 256; i++) begin
                exp.push_back(mem[i]);
                s = s + mem[i];
            end
`ifdef PINGPONG_DRAIN_CSUM_EN
            exp.push_back(s);
`endif
        end
    endtask

    task automatic compare_rx(input string tag);
        int bad;
        int n;
        bad = 0;
        n = (rx.size() < exp.size()) ? rx.size() : exp.size();
        check({tag, "_count"}, rx.size(), exp.size());
        for (int i = 0; i < n; i++)
            if (rx[i] !== exp[i])
                bad++;
        check({tag, "_bytes_wrong"}, bad, 0);
    endtask

    task automatic wait_rx(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (rx.size() >= n)
                break;
            tick();
        end
        tick(12);
    endtask

    task automatic wait_addr(input logic [7:0] a, input string tag);
        int ok;
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            if (read_addr == a) begin
                ok = 1;
                break;
            end
            tick();
        end
        check(tag, ok, 1);
    endtask

    task automatic latency(input string tag);
        int lat;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (tx_valid) begin
                lat = k;
                break;
            end
        end
        check(tag, lat, 3);
    endtask

    task automatic run_drain(input string tag);
        do_reset();
        rx.delete();
        bank_sel = ~bank_sel;
        wait_rx(DLEN, 3000);
        build_exp(1);
        compare_rx(tag);
    endtask

    initial begin
        int stable;
        int idle;
        int ok;

        for (int i = 0; i < 256; i++) begin
            mem[i]  = 8'(i);
            mem4[i] = 8'hEE;
        end
        mem4[0] = 8'hA0;
        mem4[1] = 8'hA1;
        mem4[2] = 8'hA2;
        mem4[3] = 8'hA3;

        // Reset state
        do_reset();
        check("rst_tx_valid", tx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_read_addr", read_addr, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_overrun", overrun, 0);
        tick(4);
        check("rst_no_spurious", busy, 0);

        // Full drain of 0x00..0xFF
        rx.delete();
        bank_sel = 1'b1;
        latency("t1_latency");
        wait_rx(DLEN, 3000);
        build_exp(1);
        compare_rx("t1");
        check("t1_busy_end", busy, 0);
        check("t1_overrun", overrun, 0);
        check("t1_addr_end", read_addr, 8'hFF);

        // Back-pressure at byte 0x10
        do_reset();
        rx.delete();
        bank_sel = 1'b0;
        wait_addr(8'h10, "t2_reach");
        tx_ready = 1'b0;
        check("t2_pre_count", rx.size(), 16);
        for (int i = 0; i < 10; i++) begin
            if (tx_valid)
                break;
            tick();
        end
        stable = 0;
        repeat (5) begin
            tick();
            if (tx_valid && tx_data == 8'h10)
                stable++;
        end
        check("t2_hold", stable, 5);
        check("t2_no_xfer", rx.size(), 16);
        tx_ready = 1'b1;
        wait_rx(DLEN, 3000);
        build_exp(1);
        compare_rx("t2");

        // Second flip mid-drain
        do_reset();
        rx.delete();
        bank_sel = 1'b1;
        wait_addr(8'd100, "t3_reach");
        bank_sel = 1'b0;
        tick();
        check("t3_overrun", overrun, 1);
        check("t3_busy", busy, 1);
        for (int i = 0; i < 3000; i++) begin
            if (rx.size() >= DLEN)
                break;
            tick();
        end
        idle = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy)
                break;
            idle++;
            tick();
        end
        check("t3_idle_cycles", idle, 1);
        check("t3_restart_addr", read_addr, 0);
        wait_rx(2 * DLEN, 3000);
        build_exp(2);
        compare_rx("t3");
        check("t3_overrun_sticky", overrun, 1);
        check("t3_busy_end", busy, 0);

        // Reset mid-drain
        do_reset();
        rx.delete();
        bank_sel = 1'b1;
        wait_addr(8'd50, "t4_reach");
        rst = 1'b1;
        tick();
        check("t4_tx_valid", tx_valid, 0);
        check("t4_busy", busy, 0);
        check("t4_read_addr", read_addr, 0);
        rst = 1'b0;
        ok = rx.size();
        tick(20);
        check("t4_quiet", rx.size(), ok);
        check("t4_idle", busy, 0);
        rx.delete();
        bank_sel = 1'b0;
        latency("t4_latency");
        wait_rx(DLEN, 3000);
        build_exp(1);
        compare_rx("t4");

        // DEPTH=4 instance
        rx4.delete();
        max4 = 0;
        bank_sel4 = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (rx4.size() >= DLEN4)
                break;
            tick();
        end
        tick(12);
        check("t5_count", rx4.size(), DLEN4);
        if (rx4.size() >= 4) begin
            check("t5_b0", rx4[0], 8'hA0);
            check("t5_b3", rx4[3], 8'hA3);
        end
`ifdef PINGPONG_DRAIN_CSUM_EN
        if (rx4.size() >= 5)
            check("t5_csum", rx4[4], 8'h86);
`endif
        check("t5_max_addr", max4, 3);
        check("t5_busy_end", busy4, 0);

`ifdef PINGPONG_DRAIN_CSUM_EN
        for (int i = 0; i < 256; i++) mem[i] = 8'h01;
        run_drain("c1");
        check("c1_sum", rx[256], 8'h00);
        for (int i = 0; i < 256; i++) mem[i] = 8'h02;
        run_drain("c2");
        check("c2_sum", rx[256], 8'h00);
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = 8'h05;
        run_drain("c3");
        check("c3_sum", rx[256], 8'h05);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pingpong_drain.md
PINGPONG_DRAIN -- requirements
Module: pingpong_drain

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning the number of bytes drained per bank (legal range 1..256).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port bank_sel, input, 1 bit: the current write-bank bit (write_addr[8]) from the upstream writer.
REQ-005 SHALL have port read_addr, output, 8 bits: registered byte address into the read bank of the ping-pong RAM.
REQ-006 SHALL have port ram_dout, input, 8 bits: RAM read data, valid one clock after read_addr.
REQ-007 SHALL have port tx_data, output, 8 bits: registered byte to the downstream consumer.
REQ-008 SHALL have port tx_valid, output, 1 bit: tx_data is valid.
REQ-009 SHALL have port tx_ready, input, 1 bit: the consumer accepts tx_data this cycle.
REQ-010 SHALL have port busy, output, 1 bit: a drain is in progress.
REQ-011 SHALL have port overrun, output, 1 bit: sticky flag, bank flipped during a drain.

Function
REQ-012 SHALL register bank_sel into bank_q every cycle; flip = bank_sel XOR bank_q.
REQ-013 SHALL use FSM states IDLE, RADDR, RDATA, SEND and, when configured in, CSUM.
REQ-014 IDLE: on flip (or pending=1), SHALL set read_addr=0 and go to RADDR.
REQ-015 RADDR: holds read_addr for the RAM to sample; SHALL go to RDATA next cycle.
REQ-016 RDATA: SHALL capture ram_dout into tx_data, set tx_valid=1 and go to SEND.
REQ-017 SEND: SHALL hold tx_data/tx_valid stable until tx_valid&&tx_ready; a transfer occurs only in that cycle.
REQ-018 On transfer with read_addr<DEPTH-1, SHALL increment read_addr, clear tx_valid and go to RADDR.
REQ-019 On transfer with read_addr==DEPTH-1, SHALL go to CSUM if configured, else IDLE; read_addr never wraps past DEPTH-1.
REQ-020 Latency: SHALL assert tx_valid 3 cycles after the first cycle flip=1; throughput is 1 byte per 3 cycles with tx_ready held high.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 A flip while busy=1 SHALL set overrun=1 (held until rst) and set pending=1; the current drain completes unchanged.
REQ-023 When a drain ends with pending=1, SHALL clear pending and start the next drain from read_addr=0, passing through IDLE for exactly one cycle.
REQ-024 A flip coinciding with the final transfer SHALL count as an overrun and set pending.
REQ-025 tx_ready asserted while tx_valid=0 SHALL have no effect.

Reset
REQ-026 rst SHALL force state=IDLE, read_addr=0, tx_data=0, tx_valid=0, busy=0, overrun=0, pending=0, checksum=0, and bank_q=bank_sel, so no drain starts spuriously after reset.
REQ-027 rst mid-drain SHALL abort the drain without completing the current byte; the next drain starts only on a new flip.

Configuration
REQ-028 Macro PINGPONG_DRAIN_CSUM_EN, when defined: SHALL accumulate an 8-bit modulo-256 sum of the DEPTH transferred bytes and send it as one extra byte in CSUM, with the same valid/ready rule, before IDLE.
REQ-029 Macro PINGPONG_DRAIN_CSUM_EN, when undefined: the CSUM state and accumulator SHALL not exist, and each drain is exactly DEPTH bytes.

Structure
REQ-030 Package pingpong_pkg SHALL hold the FSM state typedef and the constants BANK_ADDR_W=8 and BANK_BYTES=256.
REQ-031 Sub-module bank_flip_det SHALL contain bank_q, flip detection and the pending/overrun logic.

Verification
REQ-032 Reset, then bank_sel 0->1 with RAM bank 0 holding addr[7:0], tx_ready=1: SHALL give 256 transfers 0x00..0xFF, first tx_valid 3 cycles after the flip, then busy=0.
REQ-033 Same stimulus with tx_ready low for 5 cycles at byte 0x10: SHALL hold tx_data=0x10 stable for those cycles, with no duplicated or lost byte.
REQ-034 Second flip at byte 100: SHALL give overrun=1, finish the first 256 bytes, then after 1 IDLE cycle start a second drain at read_addr=0.
REQ-035 rst asserted at byte 50: next cycle SHALL show tx_valid=0, busy=0, read_addr=0, with no output until a new flip.
REQ-036 PINGPONG_DRAIN_CSUM_EN defined, bank holding all 0x01: SHALL give a 257th byte of 0x00 (256 mod 256); with all 0x02, SHALL give 0x00; with only byte 0=0x05 and others 0, SHALL give 0x05.
REQ-037 DEPTH=4, bank holding 0xA0..0xA3: SHALL give exactly 4 transfers, with read_addr never exceeding 3.
